dm_ctrl: RTL

- Parametrised data-memory controller for the next-generation (multi-cycle) computer top.
- Replaces the combinational data memory with a request/acknowledge interface, programmable wait states, byte/half/word access with sign or zero extension, and misalignment/illegal-access error reporting.
- Sits between the CPU load/store path and the data RAM array, which is internal to this block.

---
 rtl/dm_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/dm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dm_ctrl
//  Purpose  : Request/acknowledge data-memory controller with an internal RAM,
//             programmable wait states, sized/extended accesses and error flag.
//  Revision : 1.0 - initial release
// ============================================================================
module dm_ctrl #(
    parameter int ADDR_W = 9,
    parameter int WAIT   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [2:0]        digit,
    output logic              ready,
    output logic              ack,
    output logic [31:0]       rdata,
    output logic              err
);

    localparam int         c_DEPTH = 1 << (ADDR_W - 2);
    localparam logic [3:0] c_WAIT  = 4'(WAIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [2:0]          r_digit;
    logic [31:0]         r_mem [0:c_DEPTH-1];

    logic                w_commit;
    logic                w_op_we;
    logic [ADDR_W-1:0]   w_op_addr;
    logic [31:0]         w_op_wdata;
    logic [2:0]          w_op_digit;
    logic [ADDR_W-3:0]   w_idx;
    logic                w_err;
    logic [31:0]         w_rword;
    logic [31:0]         w_bsh;
    logic [31:0]         w_hsh;
    logic [31:0]         w_load;
    logic [31:0]         w_wlane;
    logic [3:0]          w_be;

    // With no wait states the access commits on its acceptance edge, so the
    // live request fields are used; otherwise the latched copy is used.
    assign w_op_we    = (r_state == S_IDLE) ? we    : r_we;
    assign w_op_addr  = (r_state == S_IDLE) ? addr  : r_addr;
    assign w_op_wdata = (r_state == S_IDLE) ? wdata : r_wdata;
    assign w_op_digit = (r_state == S_IDLE) ? digit : r_digit;

    assign w_commit = !reset &&
                      (((r_state == S_IDLE) && req && (c_WAIT == 4'd0)) ||
                       ((r_state == S_BUSY) && (r_cnt == 4'd1)));

    assign w_idx   = w_op_addr[ADDR_W-1:2];
    assign w_rword = r_mem[w_idx];
    assign w_bsh   = w_rword >> {w_op_addr[1:0], 3'b000};
    assign w_hsh   = w_rword >> {w_op_addr[1], 4'b0000};

    always_comb begin
        w_err = 1'b0;
        case (w_op_digit)
            3'b000:         w_err = (w_op_addr[1:0] != 2'b00);
            3'b001, 3'b010: w_err = w_op_addr[0];
            3'b011, 3'b100: w_err = 1'b0;
            default:        w_err = 1'b1;
        endcase
    end

    always_comb begin
        w_load = 32'h0;
        case (w_op_digit)
            3'b000:  w_load = w_rword;
            3'b001:  w_load = {{16{w_hsh[15]}}, w_hsh[15:0]};
            3'b010:  w_load = {16'h0, w_hsh[15:0]};
            3'b011:  w_load = {{24{w_bsh[7]}}, w_bsh[7:0]};
            3'b100:  w_load = {24'h0, w_bsh[7:0]};
            default: w_load = 32'h0;
        endcase
    end

    // Store data is replicated across lanes; the byte enables pick the target.
    always_comb begin
        w_be    = 4'b0000;
        w_wlane = w_op_wdata;
        case (w_op_digit)
            3'b000: begin
                w_be    = 4'b1111;
                w_wlane = w_op_wdata;
            end
            3'b001, 3'b010: begin
                w_be    = w_op_addr[1] ? 4'b1100 : 4'b0011;
                w_wlane = {2{w_op_wdata[15:0]}};
            end
            3'b011, 3'b100: begin
                w_be    = 4'b0001 << w_op_addr[1:0];
                w_wlane = {4{w_op_wdata[7:0]}};
            end
            default: begin
                w_be    = 4'b0000;
                w_wlane = w_op_wdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_commit && w_op_we && !w_err) begin
            for (int n = 0; n < 4; n++) begin
                if (w_be[n]) begin
                    r_mem[w_idx][8*n +: 8] <= w_wlane[8*n +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            ready   <= 1'b1;
            ack     <= 1'b0;
            rdata   <= 32'h0;
            err     <= 1'b0;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 32'h0;
            r_digit <= 3'b000;
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_we    <= we;
                        r_addr  <= addr;
                        r_wdata <= wdata;
                        r_digit <= digit;
                        r_cnt   <= c_WAIT;
                        r_state <= S_BUSY;
                        ready   <= 1'b0;
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt - 4'd1;
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    ready   <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    ready   <= 1'b1;
                end
            endcase
            if (w_commit) begin
                r_state <= S_RESP;
                ready   <= 1'b0;
                ack     <= 1'b1;
                err     <= w_err;
                if (w_err) begin
                    rdata <= 32'h0;
                end else if (!w_op_we) begin
                    rdata <= w_load;
                end
            end
        end
    end

endmodule
`default_nettype wire
